median_filter: RTL and testbench

//   3x3 median filter on a streamed raster grayscale image (default 200x200). Removes impulse noise.

---
 rtl/median_filter.sv | 110 +++++++++++
 tb/tb_median_filter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/median_filter.sv
// median_filter: 3x3 streaming median over a raster image using two line buffers
// and a pipelined sorting network; border pixels pass through unchanged.
module median_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 200,
    parameter int HEIGHT     = 200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] gray,
    input  logic                  gray_valid,
    input  logic                  gray_hsync,
    input  logic                  gray_vsync,
    output logic [DATA_WIDTH-1:0] median,
    output logic                  median_valid,
    output logic                  median_hsync,
    output logic                  median_vsync
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    typedef logic [DATA_WIDTH-1:0] pix_t;

    function automatic pix_t mn(pix_t a, pix_t b);
        return a < b ? a : b;
    endfunction

    function automatic pix_t mx(pix_t a, pix_t b);
        return a > b ? a : b;
    endfunction

    function automatic pix_t med3(pix_t a, pix_t b, pix_t c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    pix_t          lb0_q [WIDTH];
    pix_t          lb1_q [WIDTH];
    pix_t          win_q [3][3];
    pix_t          lo1_q [3];
    pix_t          mi1_q [3];
    pix_t          hi1_q [3];
    pix_t          raw_q [4];
    pix_t          a2_q, b2_q, d2_q, m3_q, median_q, median_d;
    logic [3:0]    brd_q, v_q, hs_q, vs_q;
    logic          mv_q, mh_q, mvs_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          acc, eol;

    always_comb begin
        acc      = gray_valid && gray_vsync;
        eol      = col_q == CW'(WIDTH - 1);
        col_d    = !gray_vsync ? '0 : !gray_valid ? col_q : eol ? '0 : col_q + 1'b1;
        row_d    = !gray_vsync ? '0 : !(gray_valid && eol) ? row_q :
                   row_q == RW'(HEIGHT - 1) ? '0 : row_q + 1'b1;
        median_d = v_q[3] ? (brd_q[3] ? raw_q[3] : m3_q) : median_q;
    end

    // win_q[column: 0 oldest .. 2 newest][row: 0 top .. 2 current line]
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= gray;
            win_q[0]     <= win_q[1];
            win_q[1]     <= win_q[2];
            win_q[2]     <= '{lb1_q[col_q], lb0_q[col_q], gray};
            brd_q[0]     <= (row_q < RW'(2)) || (col_q < CW'(2));
            raw_q[0]     <= gray;
        end
        for (int i = 0; i < 3; i++) begin
            lo1_q[i] <= mn(mn(win_q[i][0], win_q[i][1]), win_q[i][2]);
            mi1_q[i] <= med3(win_q[i][0], win_q[i][1], win_q[i][2]);
            hi1_q[i] <= mx(mx(win_q[i][0], win_q[i][1]), win_q[i][2]);
        end
        for (int i = 1; i < 4; i++) raw_q[i] <= raw_q[i-1];
        brd_q[3:1] <= brd_q[2:0];
        a2_q       <= mx(mx(lo1_q[0], lo1_q[1]), lo1_q[2]);
        b2_q       <= med3(mi1_q[0], mi1_q[1], mi1_q[2]);
        d2_q       <= mn(mn(hi1_q[0], hi1_q[1]), hi1_q[2]);
        m3_q       <= med3(a2_q, b2_q, d2_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q    <= '0;
            row_q    <= '0;
            v_q      <= '0;
            hs_q     <= '0;
            vs_q     <= '0;
            mv_q     <= 1'b0;
            mh_q     <= 1'b0;
            mvs_q    <= 1'b0;
            median_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            v_q      <= {v_q[2:0], gray_valid};
            hs_q     <= {hs_q[2:0], gray_hsync};
            vs_q     <= {vs_q[2:0], gray_vsync};
            mv_q     <= v_q[3];
            mh_q     <= hs_q[3];
            mvs_q    <= vs_q[3];
            median_q <= median_d;
        end
    end

    assign median       = median_q;
    assign median_valid = mv_q;
    assign median_hsync = mh_q;
    assign median_vsync = mvs_q;
endmodule

// File: tb/tb_median_filter.sv
// tb_median_filter: randomized/directed frames checked against a sort-nine-values image model,
// including gaps, border pass-through, sync delay, value hold and mid-frame reset.
module tb_median_filter;
    localparam int W = 20;
    localparam int H = 14;

    logic       clk = 0, reset_n = 1;
    logic [7:0] gray = 0;
    logic       gray_valid = 0, gray_hsync = 0, gray_vsync = 0;
    logic [7:0] median;
    logic       median_valid, median_hsync, median_vsync;

    median_filter #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset_n(reset_n), .gray(gray), .gray_valid(gray_valid),
        .gray_hsync(gray_hsync), .gray_vsync(gray_vsync), .median(median),
        .median_valid(median_valid), .median_hsync(median_hsync), .median_vsync(median_vsync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        int         t;
    } exp_t;

    int         cyc = 0;
    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] img [H][W];
    bit         hs_h [0:16383];
    bit         vs_h [0:16383];
    int         vectors = 0, errors = 0, sync_from = 1 << 30;
    logic [7:0] last_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_pix(int r, int c);
        int s[9];
        int k = 0;
        int t;
        if (r < 2 || c < 2) return img[r][c];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                s[k] = int'(img[r-2+dr][c-2+dc]);
                k++;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return 8'(s[4]);
    endfunction

    always @(negedge clk) if (reset_n) begin
        if (cyc >= sync_from) begin
            vectors++;
            assert (median_hsync === hs_h[cyc-4] && median_vsync === vs_h[cyc-4]) else begin
                errors++;
                $error("FAIL sync cyc=%0d observed hs/vs=%b%b expected %b%b", cyc,
                       median_hsync, median_vsync, hs_h[cyc-4], vs_h[cyc-4]);
            end
        end
        vectors++;
        if (median_valid) begin
            if (q.size() == 0) begin
                errors++;
                $error("FAIL extra_valid cyc=%0d observed median=%h expected no output", cyc, median);
            end else begin
                mon_e = q.pop_front();
                assert (median === mon_e.v && cyc == mon_e.t + 4) else begin
                    errors++;
                    $error("FAIL pixel cyc=%0d observed %h expected %h at cyc %0d", cyc, median,
                           mon_e.v, mon_e.t + 4);
                end
                last_exp = mon_e.v;
            end
        end else begin
            assert (median === last_exp) else begin
                errors++;
                $error("FAIL hold cyc=%0d observed %h expected %h", cyc, median, last_exp);
            end
        end
    end

    task automatic step(input bit v, input bit hs, input bit vs, input logic [7:0] g, input logic [7:0] e);
        @(negedge clk);
        gray = g; gray_valid = v; gray_hsync = hs; gray_vsync = vs;
        hs_h[cyc+1] = hs;
        vs_h[cyc+1] = vs;
        if (v && vs) q.push_back('{e, cyc + 1});
    endtask

    task automatic chk_rst();
        #1;
        vectors++;
        assert (median === 8'h00 && !median_valid && !median_hsync && !median_vsync) else begin
            errors++;
            $error("FAIL reset observed %h/%b%b%b expected 00/000", median, median_valid,
                   median_hsync, median_vsync);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sync_from = 1 << 30;
        reset_n = 0; gray_valid = 0; gray_hsync = 0; gray_vsync = 0;
        chk_rst();
        q.delete();
        last_exp = 0;
        repeat (3) begin
            @(negedge clk);
            chk_rst();
        end
        @(negedge clk);
        reset_n = 1;
        hs_h[cyc+1] = 0;
        vs_h[cyc+1] = 0;
        sync_from = cyc + 5;
    endtask

    task automatic frame(input int gap_pct, input int rst_at);
        int n = 0;
        int k = 0;
        repeat (2) step(0, 0, 1, 0, 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n == rst_at) begin
                    do_reset();
                    return;
                end
                while ($urandom_range(99) < gap_pct) step(0, 1, 1, 8'($urandom), 0);
                step(1, 1, 1, img[r][c], ref_pix(r, c));
                n++;
            end
            step(0, 0, 1, 0, 0);
        end
        repeat (3) step(0, 0, 0, 0, 0);
        while (q.size() != 0 && k < 40) begin
            step(0, 0, 0, 0, 0);
            k++;
        end
        vectors++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain observed %0d pending outputs expected 0", q.size());
        end
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = kind == 0 ? 8'h80 : kind == 1 ? ((r == 8 && c == 8) ? 8'hFF : 8'h00) :
                            kind == 2 ? ((r >= 8 && r <= 10 && c >= 8 && c <= 10) ? 8'hFF : 8'h00) :
                            kind == 3 ? 8'(r + c) : 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        fill(0); frame(0, -1);
        fill(1); frame(0, -1);
        fill(2); frame(0, -1);
        fill(3); frame(0, -1);
        fill(4); frame(0, -1); frame(30, -1);
        fill(4); frame(30, 150); frame(0, -1);
        repeat (2) step(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
